// File: rtl/clk_div_gen.sv
// clk_div_gen: runtime-programmable clock-enable generator.
// Produces a one-cycle tick per period and a registered square wave on
// the system clock. A new divisor is staged in a shadow register and is
// only applied at a period boundary, so no period is ever cut short.
module clk_div_gen #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_ld,
  output logic             tick,
  output logic             clk_out,
  output logic [CNT_W-1:0] div_cur,
  output logic             ld_pend
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO    = '0;

  // Divisors 0 and 1 both mean divide-by-1.
  function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] v);
    return (v == ZERO) ? ONE : v;
  endfunction

  // High phase covers the upper floor(d/2) counts; odd d spends the extra
  // cycle in the low phase.
  function automatic logic phase_hi(input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] d);
    return c >= (d - (d >> 1));
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] div_nxt;
  logic             wrap;

  // Effective divisor, boundary detect and the divisor chosen for the next period.
  always_comb begin
    d       = eff_div(div_cur);
    cnt_inc = cnt + ONE;
    wrap    = en && (cnt == (d - ONE));
    div_nxt = div_cur;
    if (div_ld) begin
      div_nxt = div_in;
    end else if (ld_pend) begin
      div_nxt = shadow;
    end
  end

  // Counter, outputs and divisor staging, in priority order sync_clr > !en > wrap > count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= ZERO;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      div_cur <= DEF_DIV;
      shadow  <= DEF_DIV;
      ld_pend <= 1'b0;
    end else if (sync_clr) begin
      cnt     <= ZERO;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      div_cur <= div_nxt;
      ld_pend <= 1'b0;
      if (div_ld) begin
        shadow <= div_in;
      end
    end else if (!en) begin
      tick <= 1'b0;
      if (div_ld) begin
        shadow  <= div_in;
        ld_pend <= 1'b1;
      end
    end else if (wrap) begin
      cnt     <= ZERO;
      tick    <= 1'b1;
      clk_out <= phase_hi(ZERO, eff_div(div_nxt));
      div_cur <= div_nxt;
      ld_pend <= 1'b0;
      if (div_ld) begin
        shadow <= div_in;
      end
    end else begin
      cnt     <= cnt_inc;
      tick    <= 1'b0;
      clk_out <= phase_hi(cnt_inc, d);
      if (div_ld) begin
        shadow  <= div_in;
        ld_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed bench for clk_div_gen with hand-computed
// expectations for tick, clk_out, div_cur and ld_pend.
module tb_clk_div_gen;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             sync_clr;
  logic [CNT_W-1:0] div_in;
  logic             div_ld;
  logic             tick;
  logic             clk_out;
  logic [CNT_W-1:0] div_cur;
  logic             ld_pend;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clk_div_gen #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .div_in   (div_in),
    .div_ld   (div_ld),
    .tick     (tick),
    .clk_out  (clk_out),
    .div_cur  (div_cur),
    .ld_pend  (ld_pend)
  );

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // n edges from the start of a period (count 0); thr is the first count with clk_out high.
  task automatic run_check(input string tag, input int n, input int period, input int thr);
    int c;
    for (int j = 1; j <= n; j++) begin
      step();
      c = j % period;
      chk($sformatf("%s_tick_%0d", tag, j), {31'd0, tick}, (c == 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s_clk_%0d", tag, j), {31'd0, clk_out}, (c >= thr) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic pulse_ld(input logic [CNT_W-1:0] v);
    div_in = v;
    div_ld = 1'b1;
    step();
    div_ld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync_clr = 1'b0; div_ld = 1'b0; div_in = '0;
    step();
    step();
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_clk", {31'd0, clk_out}, 32'd0);
    chk("rst_div", {16'd0, div_cur}, 32'd4);
    chk("rst_pend", {31'd0, ld_pend}, 32'd0);

    // 1: default divide-by-4
    rst = 1'b0;
    en  = 1'b1;
    run_check("t1", 12, 4, 2);
    chk("t1_div", {16'd0, div_cur}, 32'd4);
    chk("t1_pend", {31'd0, ld_pend}, 32'd0);

    // 2: mid-period load of 10 at count 1
    step();                       // count 1
    pulse_ld(16'd10);             // count 2, load staged
    chk("t2_pend_a", {31'd0, ld_pend}, 32'd1);
    chk("t2_div_a", {16'd0, div_cur}, 32'd4);
    chk("t2_tick_a", {31'd0, tick}, 32'd0);
    step();                       // count 3
    chk("t2_pend_b", {31'd0, ld_pend}, 32'd1);
    step();                       // boundary: old period completes
    chk("t2_tick_b", {31'd0, tick}, 32'd1);
    chk("t2_div_b", {16'd0, div_cur}, 32'd10);
    chk("t2_pend_c", {31'd0, ld_pend}, 32'd0);
    chk("t2_clk_b", {31'd0, clk_out}, 32'd0);
    run_check("t2", 20, 10, 5);

    // 3a: odd divisor 5
    pulse_ld(16'd5);              // count 1 of a d=10 period
    chk("t3a_pend", {31'd0, ld_pend}, 32'd1);
    repeat (8) step();            // count 9
    chk("t3a_tick_a", {31'd0, tick}, 32'd0);
    chk("t3a_div_a", {16'd0, div_cur}, 32'd10);
    step();
    chk("t3a_tick_b", {31'd0, tick}, 32'd1);
    chk("t3a_div_b", {16'd0, div_cur}, 32'd5);
    chk("t3a_pend_b", {31'd0, ld_pend}, 32'd0);
    run_check("t3a", 10, 5, 3);

    // 3b: divisor 0 then 1, both divide-by-1
    pulse_ld(16'd0);              // count 1
    repeat (3) step();            // count 4
    chk("t3b_tick_a", {31'd0, tick}, 32'd0);
    step();
    chk("t3b_tick_b", {31'd0, tick}, 32'd1);
    chk("t3b_div0", {16'd0, div_cur}, 32'd0);
    chk("t3b_clk_b", {31'd0, clk_out}, 32'd0);
    run_check("t3b0", 4, 1, 1);
    pulse_ld(16'd1);              // every edge is a boundary: applied at once
    chk("t3b_div1", {16'd0, div_cur}, 32'd1);
    chk("t3b_tick_c", {31'd0, tick}, 32'd1);
    chk("t3b_pend_c", {31'd0, ld_pend}, 32'd0);
    run_check("t3b1", 3, 1, 1);

    // 4: enable gating with d=4, frozen at count 3 (clk_out high)
    pulse_ld(16'd4);
    chk("t4_div", {16'd0, div_cur}, 32'd4);
    chk("t4_pend", {31'd0, ld_pend}, 32'd0);
    run_check("t4a", 3, 4, 2);
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("t4_hold_tick_%0d", k), {31'd0, tick}, 32'd0);
      chk($sformatf("t4_hold_clk_%0d", k), {31'd0, clk_out}, 32'd1);
    end
    en = 1'b1;
    step();
    chk("t4_resume_tick", {31'd0, tick}, 32'd1);
    chk("t4_resume_clk", {31'd0, clk_out}, 32'd0);
    step();                       // count 1
    chk("t4_after_tick", {31'd0, tick}, 32'd0);

    // 5a: sync_clr applies the pending shadow of 6
    pulse_ld(16'd6);              // count 2
    chk("t5a_pend", {31'd0, ld_pend}, 32'd1);
    chk("t5a_div_a", {16'd0, div_cur}, 32'd4);
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    chk("t5a_tick", {31'd0, tick}, 32'd0);
    chk("t5a_clk", {31'd0, clk_out}, 32'd0);
    chk("t5a_div_b", {16'd0, div_cur}, 32'd6);
    chk("t5a_pend_b", {31'd0, ld_pend}, 32'd0);
    run_check("t5a", 6, 6, 3);

    // 5b: sync_clr together with a load of 3
    sync_clr = 1'b1;
    div_in   = 16'd3;
    div_ld   = 1'b1;
    step();
    sync_clr = 1'b0;
    div_ld   = 1'b0;
    chk("t5b_div", {16'd0, div_cur}, 32'd3);
    chk("t5b_tick", {31'd0, tick}, 32'd0);
    chk("t5b_pend", {31'd0, ld_pend}, 32'd0);
    run_check("t5b", 6, 3, 2);

    // 6: async reset mid-period with d=10, count 7, load pending
    pulse_ld(16'd10);             // count 1
    step();                       // count 2
    step();                       // boundary
    chk("t6_div_a", {16'd0, div_cur}, 32'd10);
    repeat (6) step();            // count 6
    pulse_ld(16'd7);              // count 7, load pending
    chk("t6_clk_a", {31'd0, clk_out}, 32'd1);
    chk("t6_pend_a", {31'd0, ld_pend}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_tick_r", {31'd0, tick}, 32'd0);
    chk("t6_clk_r", {31'd0, clk_out}, 32'd0);
    chk("t6_div_r", {16'd0, div_cur}, 32'd4);
    chk("t6_pend_r", {31'd0, ld_pend}, 32'd0);
    #1 rst = 1'b0;
    run_check("t6", 8, 4, 2);
    chk("t6_div_b", {16'd0, div_cur}, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
